// File: rtl/fft_pkg.sv
// Shared types for the twiddle address sequencer: FSM encoding and bridge ROM latency.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BUBBLE,
    DONE
  } state_t;

  // Cycles from tact_rom to tdr_rom_real/imag at the twiddle ROM bridge.
  localparam int TW_ROM_LAT = 3;

endpackage

// File: rtl/bf_index_counter.sv
// Nested p (outer) / g (inner) / stage counter for radix-2 DIT butterflies; derives k, a, b
// combinationally from the current count and advances by one butterfly per 'advance'.
module bf_index_counter
  import fft_pkg::*;
#(
  parameter int FFT_N = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       advance,
  output logic [FFT_N-2:0]           k,
  output logic [FFT_N-1:0]           a,
  output logic [FFT_N-1:0]           b,
  output logic [$clog2(FFT_N)-1:0]   stage,
  output logic                       last_of_stage,
  output logic                       last_of_xfer
);

  localparam int W  = FFT_N - 1;
  localparam int SW = $clog2(FFT_N);
  localparam logic [W-1:0]     ONES  = '1;
  localparam logic [FFT_N-1:0] ONE_N = 1;

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W-1:0] p_max;
  logic [W-1:0] g_max;

  // p spans h = 2^s values, g spans G = 2^(FFT_N-1-s) values.
  always_comb begin
    g_max         = ONES >> stage;
    p_max         = ONES >> (W - int'(stage));
    k             = p << (W - int'(stage));
    a             = ({g, 1'b0} << stage) | {1'b0, p};
    b             = a | (ONE_N << stage);
    last_of_stage = (p == p_max) && (g == g_max);
    last_of_xfer  = last_of_stage && (stage == SW'(W));
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      p     <= '0;
      g     <= '0;
      stage <= '0;
    end else if (advance) begin
      if (last_of_stage) begin
        p     <= '0;
        g     <= '0;
        stage <= last_of_xfer ? '0 : stage + SW'(1);
      end else if (g == g_max) begin
        g <= '0;
        p <= p + W'(1);
      end else begin
        g <= g + W'(1);
      end
    end
  end

endmodule

// File: rtl/twiddle_addr_gen.sv
// Twiddle request / butterfly address sequencer feeding the twiddle ROM bridge; one request per cycle.
// TWGEN_ADDR_ALIGN_EN delays bf_* and done by TW_ROM_LAT cycles to line up with returned twiddles.
module twiddle_addr_gen
  import fft_pkg::*;
#(
  parameter int FFT_N = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      ifft_in,
  output logic                      busy,
  output logic                      done,
  output logic                      ifft,
  output logic                      tact_rom,
  output logic [FFT_N-2:0]          ta_rom,
  output logic                      evenOdd,
  output logic                      bf_valid,
  output logic [FFT_N-1:0]          bf_addr_a,
  output logic [FFT_N-1:0]          bf_addr_b,
  output logic [$clog2(FFT_N)-1:0]  stage
);

  localparam int SW = $clog2(FFT_N);

  state_t            state;
  logic              busy_c;
  logic              done_c;
  logic              bf_vld_c;
  logic [FFT_N-1:0]  a_c;
  logic [FFT_N-1:0]  b_c;
  logic [SW-1:0]     stage_c;
  logic [FFT_N-2:0]  prev_k;
  logic              new_stage;
  logic              last_q;

  logic [FFT_N-2:0]  cnt_k;
  logic [FFT_N-1:0]  cnt_a;
  logic [FFT_N-1:0]  cnt_b;
  logic [SW-1:0]     cnt_stage;
  logic              cnt_los;
  logic              cnt_lox;

  logic              need_read;
  logic              prev_read;
  logic              issue;

  bf_index_counter #(.FFT_N(FFT_N)) u_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (state == DONE),
    .advance       (issue),
    .k             (cnt_k),
    .a             (cnt_a),
    .b             (cnt_b),
    .stage         (cnt_stage),
    .last_of_stage (cnt_los),
    .last_of_xfer  (cnt_lox)
  );

  // The bridge has one ROM port: a read needs the previous cycle free of reads.
  always_comb begin
    need_read = new_stage || (cnt_k != prev_k);
    prev_read = tact_rom && !evenOdd;
    issue     = 1'b0;
    unique case (state)
      IDLE:    issue = start;
      RUN:     issue = !last_q && !(need_read && prev_read);
      BUBBLE:  issue = 1'b1;
      DONE:    issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy_c    <= 1'b0;
      done_c    <= 1'b0;
      ifft      <= 1'b0;
      tact_rom  <= 1'b0;
      ta_rom    <= '0;
      evenOdd   <= 1'b0;
      bf_vld_c  <= 1'b0;
      a_c       <= '0;
      b_c       <= '0;
      stage_c   <= '0;
      prev_k    <= '0;
      new_stage <= 1'b1;
      last_q    <= 1'b0;
    end else begin
      done_c   <= 1'b0;
      tact_rom <= issue;
      evenOdd  <= issue && !need_read;
      ta_rom   <= issue ? cnt_k : '0;
      bf_vld_c <= issue;
      a_c      <= issue ? cnt_a : '0;
      b_c      <= issue ? cnt_b : '0;
      stage_c  <= issue ? cnt_stage : '0;
      if (issue) begin
        prev_k    <= cnt_k;
        new_stage <= cnt_los;
        last_q    <= cnt_lox;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            busy_c <= 1'b1;
            ifft   <= ifft_in;
          end
        end
        RUN: begin
          if (last_q) begin
            state  <= DONE;
            busy_c <= 1'b0;
            done_c <= 1'b1;
            last_q <= 1'b0;
          end else if (need_read && prev_read) begin
            state <= BUBBLE;
          end
        end
        BUBBLE:  state <= RUN;
        DONE:    state <= IDLE;
      endcase
    end
  end

`ifdef TWGEN_ADDR_ALIGN_EN
  logic [TW_ROM_LAT-1:0] vld_d;
  logic [TW_ROM_LAT-1:0] done_d;
  logic [FFT_N-1:0]      a_d     [TW_ROM_LAT];
  logic [FFT_N-1:0]      b_d     [TW_ROM_LAT];
  logic [SW-1:0]         stage_d [TW_ROM_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_d  <= '0;
      done_d <= '0;
      for (int i = 0; i < TW_ROM_LAT; i++) begin
        a_d[i]     <= '0;
        b_d[i]     <= '0;
        stage_d[i] <= '0;
      end
    end else begin
      vld_d      <= {vld_d[TW_ROM_LAT-2:0], bf_vld_c};
      done_d     <= {done_d[TW_ROM_LAT-2:0], done_c};
      a_d[0]     <= a_c;
      b_d[0]     <= b_c;
      stage_d[0] <= stage_c;
      for (int i = 1; i < TW_ROM_LAT; i++) begin
        a_d[i]     <= a_d[i-1];
        b_d[i]     <= b_d[i-1];
        stage_d[i] <= stage_d[i-1];
      end
    end
  end

  assign bf_valid  = vld_d[TW_ROM_LAT-1];
  assign bf_addr_a = a_d[TW_ROM_LAT-1];
  assign bf_addr_b = b_d[TW_ROM_LAT-1];
  assign stage     = stage_d[TW_ROM_LAT-1];
  assign done      = done_d[TW_ROM_LAT-1];
  // Stay busy while the final butterflies drain through the delay line.
  assign busy      = busy_c | done_c | (|done_d[TW_ROM_LAT-2:0]);
`else
  assign bf_valid  = bf_vld_c;
  assign bf_addr_a = a_c;
  assign bf_addr_b = b_c;
  assign stage     = stage_c;
  assign done      = done_c;
  assign busy      = busy_c;
`endif

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Directed bench for twiddle_addr_gen at FFT_N=3 against a hand-built request table.
module tb_twiddle_addr_gen;

  localparam int N_LOG = 3;
  localparam int KW    = N_LOG - 1;
  localparam int SWD   = $clog2(N_LOG);
`ifdef TWGEN_ADDR_ALIGN_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ifft_in = 1'b0;
  logic busy, done, ifft, tact_rom, evenOdd, bf_valid;
  logic [KW-1:0]    ta_rom;
  logic [N_LOG-1:0] bf_addr_a, bf_addr_b;
  logic [SWD-1:0]   stage;

  // Index = cycle after accepted start (1..15); slot 0 stands for "nothing issued".
  int e_tact [16] = '{0, 1,1,1,1, 1,1,1,1, 1,0,1,0,1,0,1};
  int e_k    [16] = '{0, 0,0,0,0, 0,0,2,2, 0,0,1,0,2,0,3};
  int e_eo   [16] = '{0, 0,1,1,1, 0,1,0,1, 0,0,0,0,0,0,0};
  int e_a    [16] = '{0, 0,2,4,6, 0,4,1,5, 0,0,1,0,2,0,3};
  int e_b    [16] = '{0, 1,3,5,7, 2,6,3,7, 4,0,5,0,6,0,7};
  int e_s    [16] = '{0, 0,0,0,0, 1,1,1,1, 2,0,2,0,2,0,2};

  always #5 clk = ~clk;

  twiddle_addr_gen #(.FFT_N(N_LOG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ifft_in   (ifft_in),
    .busy      (busy),
    .done      (done),
    .ifft      (ifft),
    .tact_rom  (tact_rom),
    .ta_rom    (ta_rom),
    .evenOdd   (evenOdd),
    .bf_valid  (bf_valid),
    .bf_addr_a (bf_addr_a),
    .bf_addr_b (bf_addr_b),
    .stage     (stage)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic dir);
    ifft_in = dir;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    ifft_in = ~dir;
    cyc     = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({busy, done, ifft, tact_rom, evenOdd, bf_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got %b want 000000", {busy, done, ifft, tact_rom, evenOdd, bf_valid});
    end
    total++;
    if ({ta_rom, bf_addr_a, bf_addr_b, stage} !== '0) begin
      bad++;
      $display("FAIL reset_buses got %h want 0", {ta_rom, bf_addr_a, bf_addr_b, stage});
    end
    rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if (tact_rom !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_start got tact=%b busy=%b want 0 0", tact_rom, busy);
    end
  endtask

  task automatic test_stage(input string name, input int lo, input int hi, input bit poke);
    int idx;
    for (int c = lo; c <= hi; c++) begin
      total++;
      if (tact_rom !== e_tact[c][0] || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL %s c=%0d tact/busy/done got %b%b%b want %0d10", name, c, tact_rom, busy, done, e_tact[c]);
      end
      total++;
      if (evenOdd !== e_eo[c][0]) begin
        bad++;
        $display("FAIL %s c=%0d evenOdd got %b want %0d", name, c, evenOdd, e_eo[c]);
      end
      if (e_tact[c] == 1) begin
        total++;
        if (ta_rom !== KW'(e_k[c])) begin
          bad++;
          $display("FAIL %s c=%0d ta_rom got %0d want %0d", name, c, ta_rom, e_k[c]);
        end
      end
      idx = c - LAT;
      if (idx >= 1) begin
        total++;
        if (bf_valid !== e_tact[idx][0]) begin
          bad++;
          $display("FAIL %s c=%0d bf_valid got %b want %0d", name, c, bf_valid, e_tact[idx]);
        end
        if (e_tact[idx] == 1) begin
          total++;
          if (bf_addr_a !== N_LOG'(e_a[idx]) || bf_addr_b !== N_LOG'(e_b[idx]) || stage !== SWD'(e_s[idx])) begin
            bad++;
            $display("FAIL %s c=%0d a/b/s got %0d/%0d/%0d want %0d/%0d/%0d", name, c,
                     bf_addr_a, bf_addr_b, stage, e_a[idx], e_b[idx], e_s[idx]);
          end
        end
      end else begin
        total++;
        if (bf_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s c=%0d bf_valid_early got %b want 0", name, c, bf_valid);
        end
      end
      if (poke && c == 6) begin
        start   = 1'b1;
        ifft_in = 1'b0;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
  endtask

`ifdef TWGEN_ADDR_ALIGN_EN
  task automatic test_align_tail();
    for (int c = 16; c < 16 + LAT; c++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || tact_rom !== 1'b0 || bf_valid !== e_tact[c-LAT][0]) begin
        bad++;
        $display("FAIL align_tail c=%0d busy/done/tact/bfv got %b%b%b%b want 100%0d", c,
                 busy, done, tact_rom, bf_valid, e_tact[c-LAT]);
      end
      if (e_tact[c-LAT] == 1) begin
        total++;
        if (bf_addr_a !== N_LOG'(e_a[c-LAT]) || bf_addr_b !== N_LOG'(e_b[c-LAT])) begin
          bad++;
          $display("FAIL align_tail_addr c=%0d got %0d/%0d want %0d/%0d", c,
                   bf_addr_a, bf_addr_b, e_a[c-LAT], e_b[c-LAT]);
        end
      end
      tick();
      cyc++;
    end
  endtask
`endif

  task automatic test_done();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || tact_rom !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse c=%0d done/busy/tact got %b%b%b want 100", cyc, done, busy, tact_rom);
    end
    total++;
    if (ifft !== 1'b1) begin
      bad++;
      $display("FAIL ifft_latched got %b want 1", ifft);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_single got %b want 0", done);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || tact_rom !== 1'b0 || bf_valid !== 1'b0) begin
        bad++;
        $display("FAIL post_idle i=%0d done/busy/tact/bfv got %b%b%b%b want 0000", i, done, busy, tact_rom, bf_valid);
      end
    end
  endtask

  task automatic test_midreset();
    pulse_start(1'b1);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    total++;
    if ({busy, done, ifft, tact_rom, evenOdd, bf_valid} !== 6'b0) begin
      bad++;
      $display("FAIL midreset_flags got %b want 000000", {busy, done, ifft, tact_rom, evenOdd, bf_valid});
    end
    total++;
    if ({ta_rom, bf_addr_a, bf_addr_b, stage} !== '0) begin
      bad++;
      $display("FAIL midreset_buses got %h want 0", {ta_rom, bf_addr_a, bf_addr_b, stage});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      total++;
      if (done !== 1'b0 || tact_rom !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL midreset_quiet i=%0d done/tact/busy got %b%b%b want 000", i, done, tact_rom, busy);
      end
    end
  endtask

  task automatic test_replay();
    bit seen;
    seen = 1'b0;
    pulse_start(1'b0);
    total++;
    if (ifft !== 1'b0) begin
      bad++;
      $display("FAIL replay_ifft got %b want 0", ifft);
    end
    test_stage("replay_s0", 1, 4, 1'b0);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL replay_done got no done want done within 40 cycles");
    end
  endtask

  initial begin
    test_reset();
    pulse_start(1'b1);
    test_stage("stage0", 1, 4, 1'b0);
    test_stage("stage1", 5, 8, 1'b1);
    test_stage("stage2", 9, 15, 1'b0);
`ifdef TWGEN_ADDR_ALIGN_EN
    test_align_tail();
`endif
    test_done();
    test_midreset();
    test_replay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
